// File: rtl/ffn_token_sequencer_pkg.sv
// rtl/ffn_token_sequencer_pkg.sv - shared types and default parameters for the FFN token sequencer
package ffn_token_sequencer_pkg;

    localparam int FFN_D_IN        = 2;
    localparam int FFN_DW          = 8;
    localparam int FFN_TIMEOUT_CYC = 64;
    localparam int FFN_GAP_CYC     = 2;
    localparam int FFN_CNT_W       = 16;

    // One token in flight: accept, start the engine, wait, hand back, then rest the engine.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        GAP   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ffn_token_sequencer_if.sv
// rtl/ffn_token_sequencer_if.sv - token, engine and result streams plus status of the FFN token sequencer
interface ffn_token_sequencer_if
    import ffn_token_sequencer_pkg::*;
#(
    parameter int D_IN  = FFN_D_IN,
    parameter int DW    = FFN_DW,
    parameter int CNT_W = FFN_CNT_W
);

    // Token stream from upstream
    logic                 tok_valid;
    logic                 tok_ready;
    logic signed [DW-1:0] tok_data [0:D_IN-1];
    logic                 tok_last;

    // Engine start/out_valid handshake
    logic                 ffn_start;
    logic signed [DW-1:0] ffn_in_vec [0:D_IN-1];
    logic                 ffn_out_valid;
    logic signed [DW-1:0] ffn_out_vec [0:D_IN-1];

    // Result stream to downstream
    logic                 res_valid;
    logic                 res_ready;
    logic signed [DW-1:0] res_data [0:D_IN-1];
    logic                 res_last;

    // Status
    logic                 busy;
    logic                 err_timeout;
    logic                 err_spurious;
    logic [CNT_W-1:0]     tok_cnt;
    logic [CNT_W-1:0]     frame_cnt;

    // Sequencer side
    modport master (
        input  tok_valid, tok_data, tok_last, ffn_out_valid, ffn_out_vec, res_ready,
        output tok_ready, ffn_start, ffn_in_vec, res_valid, res_data, res_last,
        output busy, err_timeout, err_spurious, tok_cnt, frame_cnt
    );

    // Environment side: upstream source, engine and downstream sink
    modport slave (
        output tok_valid, tok_data, tok_last, ffn_out_valid, ffn_out_vec, res_ready,
        input  tok_ready, ffn_start, ffn_in_vec, res_valid, res_data, res_last,
        input  busy, err_timeout, err_spurious, tok_cnt, frame_cnt
    );

endinterface

// File: rtl/ffn_token_sequencer.sv
// rtl/ffn_token_sequencer.sv - issues one FFN engine run per token with timeout, recovery gap and frame tracking
module ffn_token_sequencer
    import ffn_token_sequencer_pkg::*;
#(
    parameter int D_IN        = FFN_D_IN,
    parameter int DW          = FFN_DW,
    parameter int TIMEOUT_CYC = FFN_TIMEOUT_CYC,
    parameter int GAP_CYC     = FFN_GAP_CYC,
    parameter int CNT_W       = FFN_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    ffn_token_sequencer_if.master bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int GAP_W = $clog2(GAP_CYC) + 1;

    // Run timer terminal value: reached on the TIMEOUT_CYC-th cycle after ffn_start.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    // Gap counter is loaded one cycle after out_valid/abort, so one gap cycle has already elapsed.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    seq_state_t           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic signed [DW-1:0] in_buf_q [0:D_IN-1];
    logic signed [DW-1:0] in_buf_d [0:D_IN-1];
    logic                 last_buf_q, last_buf_d;
    logic signed [DW-1:0] res_buf_q [0:D_IN-1];
    logic signed [DW-1:0] res_buf_d [0:D_IN-1];
    logic                 res_valid_q, res_valid_d;
    logic                 res_last_q, res_last_d;

    logic [CNT_W-1:0]     tok_cnt_q, tok_cnt_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_spurious_q, err_spurious_d;

    logic                 tok_ready_w;
    logic                 res_fire;
    logic                 run_abort;

    // Tokens are only taken in IDLE once the engine recovery gap has run out.
    always_comb begin
        tok_ready_w = (state_q == IDLE) && (gap_q == '0);
    end

    // Next state, run/gap timers and data buffers.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        gap_d       = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        in_buf_d    = in_buf_q;
        last_buf_d  = last_buf_q;
        res_buf_d   = res_buf_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        res_fire    = 1'b0;
        run_abort   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tok_ready_w && bus.tok_valid) begin
                    in_buf_d   = bus.tok_data;
                    last_buf_d = bus.tok_last;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A result on the terminal-count cycle still counts as on time.
                if (bus.ffn_out_valid) begin
                    res_buf_d   = bus.ffn_out_vec;
                    res_valid_d = 1'b1;
                    res_last_d  = last_buf_q;
                    gap_d       = GAP_LOAD;
                    state_d     = EMIT;
                end else if (timer_q == TMR_LAST) begin
                    run_abort = 1'b1;
                    gap_d     = GAP_LOAD;
                    state_d   = GAP;
                end
            end
            EMIT: begin
                if (res_valid_q && bus.res_ready) begin
                    res_fire    = 1'b1;
                    res_valid_d = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and buffer registers; reset mid-run drops the token without emitting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            gap_q       <= '0;
            last_buf_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            for (int i = 0; i < D_IN; i++) begin
                in_buf_q[i]  <= '0;
                res_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            in_buf_q    <= in_buf_d;
            last_buf_q  <= last_buf_d;
            res_buf_q   <= res_buf_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
        end
    end

    // Result/frame counters and sticky error flags.
    always_comb begin
        tok_cnt_d      = tok_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        err_timeout_d  = err_timeout_q | run_abort;
        err_spurious_d = err_spurious_q | (bus.ffn_out_valid && (state_q != WAIT));
        if (res_fire) begin
            tok_cnt_d = tok_cnt_q + CNT_W'(1);
            if (res_last_q) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and error registers; errors clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            tok_cnt_q      <= tok_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign bus.tok_ready    = tok_ready_w;
    assign bus.ffn_start    = (state_q == ISSUE);
    assign bus.ffn_in_vec   = in_buf_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_buf_q;
    assign bus.res_last     = res_last_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_spurious = err_spurious_q;
    assign bus.tok_cnt      = tok_cnt_q;
    assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_ffn_token_sequencer.sv
// tb/tb_ffn_token_sequencer.sv - self-checking bench for ffn_token_sequencer with behavioural engine and scoreboard
module tb_ffn_token_sequencer;

    localparam int D_IN        = 2;
    localparam int DW          = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int GAP_CYC     = 2;
    localparam int CNT_W       = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ffn_token_sequencer_if #(.D_IN(D_IN), .DW(DW), .CNT_W(CNT_W)) bus ();

    ffn_token_sequencer #(
        .D_IN(D_IN), .DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural engine: result = input + 4 per element, after eng_lat cycles from ffn_start.
    logic                 eng_ov    = 1'b0;
    logic                 inj_ov    = 1'b0;
    logic                 eng_busy  = 1'b0;
    logic                 eng_never = 1'b0;
    int                   eng_cnt   = 0;
    int                   eng_lat   = 10;
    logic signed [DW-1:0] eng_vec [0:D_IN-1] = '{default: '0};

    always @(posedge clk) begin
        eng_ov <= 1'b0;
        if (rst) begin
            eng_busy <= 1'b0;
        end else if (bus.ffn_start) begin
            eng_busy <= !eng_never;
            eng_cnt  <= 1;
        end else if (eng_busy) begin
            if (eng_cnt >= eng_lat - 1) begin
                eng_ov   <= 1'b1;
                eng_busy <= 1'b0;
                for (int i = 0; i < D_IN; i++) eng_vec[i] <= bus.ffn_in_vec[i] + 8'sd4;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end
    assign bus.ffn_out_valid = eng_ov | inj_ov;
    assign bus.ffn_out_vec   = eng_vec;

    // Downstream ready: fixed level or random per cycle.
    logic rr_fixed = 1'b1;
    logic rnd_en   = 1'b0;
    logic rnd_bit  = 1'b1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign bus.res_ready = rnd_en ? rnd_bit : rr_fixed;

    // ffn_start pulse monitor
    int start_cnt  = 0;
    int last_start = -1;
    always @(negedge clk) begin
        if (bus.ffn_start) begin
            start_cnt++;
            last_start = cyc;
        end
    end

    // Scoreboard: {last, d0, d1} pushed on token accept, popped on result handshake.
    logic [2*DW:0] sb_q[$];
    always @(negedge clk) begin
        logic [2*DW:0] got;
        logic [2*DW:0] exp;
        if (!rst && bus.res_valid && bus.res_ready) begin
            got = {bus.res_last, bus.res_data[0], bus.res_data[1]};
            n_tests++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected observed=%0h expected=none", got);
            end
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                n_tests++;
                assert (got === exp) else begin
                    n_fail++;
                    $error("FAIL sb_result observed=%0h expected=%0h", got, exp);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tok(input int a, input int b, input bit last, input bit expect_res,
                            output int acc);
        int k = 0;
        bus.tok_valid   = 1'b1;
        bus.tok_data[0] = DW'(a);
        bus.tok_data[1] = DW'(b);
        bus.tok_last    = last;
        while (!bus.tok_ready && k < 500) begin
            step();
            k++;
        end
        chk("tok_accept", bus.tok_ready, 1);
        if (expect_res) sb_q.push_back({last, DW'(a + 4), DW'(b + 4)});
        acc = cyc;
        step();
        bus.tok_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int n, input int budget, input string tag);
        int k = 0;
        while (bus.tok_cnt != CNT_W'(n) && k < budget) begin
            step();
            k++;
        end
        chk(tag, bus.tok_cnt, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int s;
        int r;
        int k;
        int base_t;
        int base_f;
        logic [2*DW-1:0] snap;

        bus.tok_valid   = 1'b0;
        bus.tok_data[0] = '0;
        bus.tok_data[1] = '0;
        bus.tok_last    = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_tok_ready", bus.tok_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_ffn_start", bus.ffn_start, 0);
        chk("rst_err_timeout", bus.err_timeout, 0);
        chk("rst_err_spurious", bus.err_spurious, 0);
        chk("rst_tok_cnt", bus.tok_cnt, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);

        // 1: single token, latency 10
        eng_lat = 10;
        send_tok(3, -5, 1'b1, 1'b1, acc);
        wait_cnt(1, 100, "t1_tok_cnt");
        chk("t1_start_cyc", last_start, acc + 1);
        chk("t1_start_cnt", start_cnt, 1);
        chk("t1_frame_cnt", bus.frame_cnt, 1);

        // 2: backpressure for 20 cycles with the next token waiting
        rr_fixed = 1'b0;
        eng_lat  = 4;
        send_tok(10, 20, 1'b0, 1'b1, acc);
        k = 0;
        while (!bus.res_valid && k < 100) begin
            step();
            k++;
        end
        chk("t2_res_valid", bus.res_valid, 1);
        snap = {bus.res_data[0], bus.res_data[1]};
        chk("t2_res_data", snap, {8'd14, 8'd24});
        s = start_cnt;
        bus.tok_valid   = 1'b1;
        bus.tok_data[0] = 8'sd1;
        bus.tok_data[1] = 8'sd2;
        bus.tok_last    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("t2_hold_valid", bus.res_valid, 1);
            chk("t2_hold_data", {bus.res_data[0], bus.res_data[1]}, snap);
            chk("t2_hold_ready", bus.tok_ready, 0);
            step();
        end
        rr_fixed = 1'b1;
        step();
        chk("t2_gap_ready", bus.tok_ready, 0);
        step();
        chk("t2_idle_ready", bus.tok_ready, 1);
        chk("t2_no_start", start_cnt, s);
        sb_q.push_back({1'b0, 8'd5, 8'd6});
        step();
        bus.tok_valid = 1'b0;
        chk("t2_issue", bus.ffn_start, 1);
        wait_cnt(3, 100, "t2_tok_cnt");

        // 3: engine never answers -> timeout
        eng_never = 1'b1;
        send_tok(9, 9, 1'b0, 1'b0, acc);
        s = acc + 1;
        k = 0;
        while (cyc < s + 64 && k < 200) begin
            step();
            k++;
        end
        chk("t3_err_before", bus.err_timeout, 0);
        chk("t3_busy", bus.busy, 1);
        step();
        chk("t3_err_at_64", bus.err_timeout, 1);
        chk("t3_no_res", bus.res_valid, 0);
        chk("t3_gap_ready0", bus.tok_ready, 0);
        step();
        chk("t3_gap_ready1", bus.tok_ready, 0);
        step();
        chk("t3_idle_ready", bus.tok_ready, 1);
        eng_never = 1'b0;
        eng_lat   = 3;
        send_tok(1, -1, 1'b0, 1'b1, acc);
        wait_cnt(4, 100, "t3_tok_cnt");
        chk("t3_err_sticky", bus.err_timeout, 1);
        chk("t3_no_spurious", bus.err_spurious, 0);

        // 4: spurious out_valid in IDLE
        repeat (4) step();
        chk("t4_idle", bus.busy, 0);
        inj_ov = 1'b1;
        step();
        inj_ov = 1'b0;
        chk("t4_err_spurious", bus.err_spurious, 1);
        chk("t4_res_valid", bus.res_valid, 0);
        step();
        chk("t4_tok_cnt", bus.tok_cnt, 4);
        chk("t4_res_valid2", bus.res_valid, 0);

        // 5: frame of 4 tokens with random res_ready
        base_t  = int'(bus.tok_cnt);
        base_f  = int'(bus.frame_cnt);
        rnd_en  = 1'b1;
        eng_lat = 5;
        for (int i = 0; i < 4; i++) begin
            send_tok(i * 3 + 1, -i * 2 - 7, (i == 3), 1'b1, acc);
        end
        wait_cnt(base_t + 4, 2000, "t5_tok_cnt");
        rnd_en = 1'b0;
        chk("t5_frame_cnt", bus.frame_cnt, base_f + 1);
        chk("t5_sb_empty", sb_q.size(), 0);

        // 6: reset during WAIT
        eng_lat = 30;
        send_tok(2, 2, 1'b1, 1'b1, acc);
        repeat (5) step();
        chk("t6_busy_pre", bus.busy, 1);
        rst = 1'b1;
        step();
        sb_q.delete();
        chk("t6_busy", bus.busy, 0);
        chk("t6_tok_ready", bus.tok_ready, 1);
        chk("t6_ffn_start", bus.ffn_start, 0);
        chk("t6_res_valid", bus.res_valid, 0);
        chk("t6_res_last", bus.res_last, 0);
        chk("t6_res_data", {bus.res_data[0], bus.res_data[1]}, 0);
        chk("t6_in_vec", {bus.ffn_in_vec[0], bus.ffn_in_vec[1]}, 0);
        chk("t6_err_timeout", bus.err_timeout, 0);
        chk("t6_err_spurious", bus.err_spurious, 0);
        chk("t6_tok_cnt", bus.tok_cnt, 0);
        chk("t6_frame_cnt", bus.frame_cnt, 0);
        rst = 1'b0;
        step();
        inj_ov = 1'b1;
        step();
        inj_ov = 1'b0;
        chk("t6_late_spurious", bus.err_spurious, 1);
        chk("t6_late_res_valid", bus.res_valid, 0);
        repeat (3) step();
        chk("t6_late_tok_cnt", bus.tok_cnt, 0);
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
